// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: byte FIFO capturing UART receiver output on rxFinish rising edge; UART_RX_FIFO_FWFT_EN selects first-word fall-through reads
module uart_rx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               rxData,
  input  logic                     rxFinish,
  input  logic                     rdReq,
  input  logic                     clrOverflow,
  output logic [7:0]               rdData,
  output logic                     rdValid,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0]  mem [DEPTH];
  logic        fin_q;
  logic [AW:0] wp_q, wp_d, rp_q, rp_d;
  logic        ovf_q, ovf_d;
  logic        wr, rd, push;
  assign empty    = wp_q == rp_q;
  assign full     = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign level    = wp_q - rp_q;
  assign overflow = ovf_q;
  // strobes and next-state: a pop frees a slot so a full FIFO can still accept a same-cycle push
  always_comb begin
    wr    = rxFinish & ~fin_q;
    rd    = rdReq & ~empty;
    push  = wr & (~full | rd);
    wp_d  = wp_q + (AW+1)'(push);
    rp_d  = rp_q + (AW+1)'(rd);
    ovf_d = (wr & full & ~rd) | (ovf_q & ~clrOverflow);
  end
  // edge detector, pointers and sticky overflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fin_q <= 1'b0;
      wp_q  <= '0;
      rp_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      fin_q <= rxFinish;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      ovf_q <= ovf_d;
    end
  end
  // storage array, contents are not reset
  always_ff @(posedge clk) begin
    if (push) mem[wp_q[AW-1:0]] <= rxData;
  end
`ifdef UART_RX_FIFO_FWFT_EN
  assign rdData  = mem[rp_q[AW-1:0]];
  assign rdValid = ~empty;
`else
  logic [7:0] rd_data_q, rd_data_d;
  logic       rd_valid_q;
  // registered read data holds between pops
  always_comb rd_data_d = rd ? mem[rp_q[AW-1:0]] : rd_data_q;
  // read data register and one-cycle valid pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd;
    end
  end
  assign rdData  = rd_data_q;
  assign rdValid = rd_valid_q;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: scoreboard bench for uart_rx_fifo
module tb_uart_rx_fifo;
  logic       clk = 1'b0, reset = 1'b1;
  logic [7:0] rxData = '0;
  logic       rxFinish = 1'b0, rdReq = 1'b0, clrOverflow = 1'b0;
  logic [7:0] rdData;
  logic       rdValid, empty, full, overflow;
  logic [4:0] level;
  logic [7:0] sb [$];
  int total = 0, bad = 0;
  uart_rx_fifo #(.DEPTH(16)) dut (
    .clk(clk), .reset(reset), .rxData(rxData), .rxFinish(rxFinish),
    .rdReq(rdReq), .clrOverflow(clrOverflow), .rdData(rdData),
    .rdValid(rdValid), .empty(empty), .full(full), .level(level),
    .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic write_byte(input logic [7:0] b, input bit accept);
    rxData = b;
    rxFinish = 1'b1;
    if (accept) sb.push_back(b);
    cyc();
    rxFinish = 1'b0;
    cyc();
  endtask
  task automatic drain();
    for (int k = 0; k < 40 && !empty; k++) begin
      rdReq = 1'b1;
      cyc();
    end
    rdReq = 1'b0;
    cyc();
  endtask
  // monitor: compare every delivered byte against the scoreboard head
`ifdef UART_RX_FIFO_FWFT_EN
  always @(negedge clk) if (!reset && rdReq && rdValid) begin
`else
  always @(negedge clk) if (rdValid) begin
`endif
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL read: unexpected byte %0h with empty scoreboard", rdData);
    end else begin
      logic [7:0] e;
      e = sb.pop_front();
      if (rdData !== e) begin
        bad++;
        $display("FAIL read: got %0h expected %0h", rdData, e);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
  initial begin
    #12;
    check("reset_empty", int'(empty), 1);
    check("reset_level", int'(level), 0);
    check("reset_rdvalid", int'(rdValid), 0);
    cyc();
    reset = 1'b0;
    cyc();
    // single byte, rxFinish held three cycles
    rxData = 8'hA5;
    rxFinish = 1'b1;
    sb.push_back(8'hA5);
    repeat (3) cyc();
    rxFinish = 1'b0;
    cyc();
    check("single_level", int'(level), 1);
    check("single_empty", int'(empty), 0);
    rdReq = 1'b1;
    cyc();
    rdReq = 1'b0;
`ifndef UART_RX_FIFO_FWFT_EN
    check("single_rdvalid", int'(rdValid), 1);
    check("single_rddata", int'(rdData), 8'hA5);
`endif
    check("single_level0", int'(level), 0);
    check("single_empty1", int'(empty), 1);
    cyc();
`ifndef UART_RX_FIFO_FWFT_EN
    check("single_rdvalid_pulse", int'(rdValid), 0);
    check("single_rddata_hold", int'(rdData), 8'hA5);
`endif
    // order and wrap: 48 bytes with interleaved pops
    for (int i = 0; i < 48; i++) begin
      rxData = 8'(i);
      rxFinish = 1'b1;
      sb.push_back(8'(i));
      cyc();
      rxFinish = 1'b0;
      rdReq = (level >= 5'd4);
      cyc();
      rdReq = 1'b0;
    end
    check("wrap_level_bound", int'(level <= 5'd8), 1);
    drain();
    check("wrap_overflow", int'(overflow), 0);
    check("wrap_empty", int'(empty), 1);
    // fill to full, then overflow
    for (int i = 0; i < 16; i++) write_byte(8'h10 + 8'(i), 1'b1);
    check("full_flag", int'(full), 1);
    check("full_level", int'(level), 16);
    write_byte(8'h99, 1'b0);
    check("ovf_set", int'(overflow), 1);
    check("ovf_level", int'(level), 16);
    // overflow and clear in the same cycle: set wins
    rxData = 8'hAA;
    rxFinish = 1'b1;
    clrOverflow = 1'b1;
    cyc();
    rxFinish = 1'b0;
    clrOverflow = 1'b0;
    cyc();
    check("ovf_set_wins", int'(overflow), 1);
    clrOverflow = 1'b1;
    cyc();
    clrOverflow = 1'b0;
    check("ovf_clear", int'(overflow), 0);
    // full plus push and pop in the same cycle
    rxData = 8'h77;
    rxFinish = 1'b1;
    rdReq = 1'b1;
    sb.push_back(8'h77);
    cyc();
    rxFinish = 1'b0;
    rdReq = 1'b0;
    check("fullrw_level", int'(level), 16);
    check("fullrw_ovf", int'(overflow), 0);
    cyc();
    drain();
    check("fullrw_empty", int'(empty), 1);
    // empty plus push and pop in the same cycle
    rxData = 8'h5A;
    rxFinish = 1'b1;
    rdReq = 1'b1;
    sb.push_back(8'h5A);
    cyc();
    rxFinish = 1'b0;
    rdReq = 1'b0;
    check("emptyrw_level", int'(level), 1);
`ifndef UART_RX_FIFO_FWFT_EN
    check("emptyrw_rdvalid", int'(rdValid), 0);
`endif
    cyc();
    drain();
    // reset mid-operation with five bytes stored and overflow set
    for (int i = 0; i < 16; i++) write_byte(8'h40 + 8'(i), 1'b1);
    write_byte(8'h99, 1'b0);
    for (int i = 0; i < 11; i++) begin
      rdReq = 1'b1;
      cyc();
    end
    rdReq = 1'b0;
    cyc();
    check("mid_level", int'(level), 5);
    check("mid_ovf", int'(overflow), 1);
    #2;
    reset = 1'b1;
    sb.delete();
    #1;
    check("mid_rst_empty", int'(empty), 1);
    check("mid_rst_level", int'(level), 0);
    check("mid_rst_ovf", int'(overflow), 0);
    check("mid_rst_rdvalid", int'(rdValid), 0);
`ifndef UART_RX_FIFO_FWFT_EN
    check("mid_rst_rddata", int'(rdData), 0);
`endif
    cyc();
    reset = 1'b0;
    cyc();
    write_byte(8'h3C, 1'b1);
`ifdef UART_RX_FIFO_FWFT_EN
    check("fwft_valid", int'(rdValid), 1);
    check("fwft_data", int'(rdData), 8'h3C);
`endif
    drain();
`ifdef UART_RX_FIFO_FWFT_EN
    rxData = 8'hC3;
    rxFinish = 1'b1;
    sb.push_back(8'hC3);
    cyc();
    rxFinish = 1'b0;
    check("fwft_c3_valid", int'(rdValid), 1);
    check("fwft_c3_data", int'(rdData), 8'hC3);
    rdReq = 1'b1;
    cyc();
    rdReq = 1'b0;
    check("fwft_pop_valid", int'(rdValid), 0);
`endif
    cyc();
    check("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer that sits directly downstream of the UART receiver. It captures each received byte on the receiver's completion flag and stores it in a circular FIFO. Downstream logic (the PC-link command/loopback logic) drains it through a simple read-request interface. Overflow is reported, never silent.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2. `AW = log2(DEPTH)`.
- `clk` input 1: single clock, rising-edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `rxData` input 8: byte from UART receiver; stable while `rxFinish` is high.
- `rxFinish` input 1: receiver completion flag (level); a byte is taken on its rising edge only.
- `rdReq` input 1: read/pop request from consumer.
- `clrOverflow` input 1: clears `overflow`.
- `rdData` output 8: read data.
- `rdValid` output 1: `rdData` is valid (see Timing).
- `empty` output 1: no stored bytes.
- `full` output 1: `level == DEPTH`.
- `level` output AW+1: number of stored bytes, 0..DEPTH.
- `overflow` output 1: sticky; a byte was dropped.

## Operation
- Edge detect: register `finD <= rxFinish`. Write strobe `wr = rxFinish & ~finD`; `rxData` is sampled in the same cycle. A `rxFinish` held high for many cycles yields exactly one write.
- Storage: `DEPTH x 8` array, write pointer `wp` and read pointer `rp`, each AW+1 bits. Address = low AW bits. Both pointers wrap modulo 2·DEPTH. `empty = (wp == rp)`. `full` = MSBs differ and low bits equal. `level = wp - rp` (AW+1-bit modulo subtraction).
- Pop: `rd = rdReq & ~empty`. `rdReq` while empty is ignored, with no state change.
- Push accepted when `wr & (~full | rd)`. When full with a simultaneous pop, both occur and `level` stays DEPTH.
- Overflow: `wr & full & ~rd` drops the byte and sets `overflow`. `clrOverflow` clears it. If set and clear occur in the same cycle, set wins.
- Push and pop in the same cycle on a non-empty FIFO: `level` is unchanged.
- Push and pop in the same cycle on an empty FIFO: the pop is ignored and the push is accepted.
- Reset, including mid-stream: `wp = rp = 0`, `finD = 0`, `overflow = 0`, `rdData = 0`, `rdValid = 0`, `empty = 1`, `full = 0`, `level = 0`. Array contents are don't-care.
  - If `rxFinish` is already high when reset releases, the first cycle sees `finD = 0`, so that byte is captured once.

## Timing
- Write latency: the rising edge of `rxFinish` is sampled at clock edge N. The byte is written at edge N, and `empty`, `level` and `full` reflect it after edge N.
- Default, registered read (macro undefined):
  - `rd` at edge N loads `rdData <= mem[rp]` and advances `rp`.
  - `rdValid` is high for exactly the cycle after edge N, then returns to 0 unless another `rd` occurs.
  - `rdData` holds its value between reads.
  - Back-to-back `rdReq` gives one byte per cycle.
- Status outputs are registered or derived from registered pointers. There is no combinational path from `rdReq` to `empty`, `full` or `level`.
- One push and one pop per cycle maximum.

## Configuration
- `UART_RX_FIFO_FWFT_EN` undefined: registered read as above.
- `UART_RX_FIFO_FWFT_EN` defined: first-word fall-through.
  - `rdData = mem[rp]` combinationally; `rdValid = ~empty`.
  - `rd` at edge N pops, and the next entry appears after edge N.
  - The first byte is visible on `rdData` in the cycle after its write edge.
  - `rdData` is don't-care while `rdValid = 0`.
- Pointer, flag, overflow and reset behaviour are identical in both modes.

## Test plan
- Single byte: reset, drive `rxData = 8'hA5` and pulse `rxFinish` for 3 cycles, then pop.
  - Required: exactly one write, `level = 1`, `empty = 0`.
  - Registered mode: after `rdReq`, `rdData = 8'hA5` with a one-cycle `rdValid`.
  - Then `level = 0`, `empty = 1`.
- Order and wrap: write bytes 0x00..0x2F (48 bytes) interleaved with pops, keeping `level ≤ 8` and `DEPTH = 16`.
  - Required: reads return 0x00..0x2F in order.
  - Pointers wrap at least twice; `overflow` stays 0.
- Full and overflow: write 16 bytes 0x10..0x1F, then write 0x99 with no pop.
  - Required: `full = 1`, `level = 16`, `overflow = 1`.
  - Reads return 0x10..0x1F; 0x99 is never read.
  - Pulsing `clrOverflow` clears `overflow`.
- Simultaneous events:
  - Full FIFO plus write 0x77 with `rdReq` in the same cycle: `level` stays 16, `overflow = 0`, and 0x77 is read last.
  - Empty FIFO with `rdReq` and a write in the same cycle: `level = 1`.
  - Overflow and `clrOverflow` in the same cycle: `overflow = 1`.
- Reset mid-operation: with 5 bytes stored and `overflow = 1`, assert `reset` asynchronously between clock edges.
  - Required: outputs go to reset values immediately (`empty = 1`, `level = 0`, `overflow = 0`, `rdValid = 0`).
  - A subsequent write of 0x3C is the first byte read.
- FWFT build (macro defined): write 0xC3.
  - Required: `rdValid = 1` and `rdData = 0xC3` in the cycle after the write edge, without `rdReq`.
  - Popping drops `rdValid` the next cycle.
